// File: rtl/elastic_pkg.sv
// Shared definitions for the elastic dataflow operator: operation codes and
// a constant-evaluable ceiling log2 used to size pointers and counters.
package elastic_pkg;

  typedef enum logic [2:0] {
    OP_PASS = 3'd0,
    OP_ADDI = 3'd1,
    OP_SUBI = 3'd2,
    OP_MULI = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MUL  = 3'd6
  } op_e;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/elastic_fifo.sv
// Per-lane operand buffer: synchronous push/pop, head word visible combinationally.
// DEPTH is a power of two, so the pointers wrap on their own.
module elastic_fifo
  import elastic_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  localparam int AW        = clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic [CW-1:0]         count,
  output logic                  full,
  output logic                  empty
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; count and the pointers alone decide
  // which entries are valid, so a flush never has to touch the data words.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/elastic_operator.sv
// Elastic dataflow node: buffered operand lanes, one shared result register,
// and independently acknowledged fan-out consumers.
module elastic_operator
  import elastic_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INPUT_SIZE  = 1,
  parameter int                    OUTPUT_SIZE = 1,
  parameter int                    DEPTH       = 4,
  parameter op_e                   OP          = OP_PASS,
  parameter logic [DATA_WIDTH-1:0] IMMEDIATE   = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  output logic [INPUT_SIZE-1:0]            req_l,
  input  logic [INPUT_SIZE-1:0]            ack_l,
  input  logic [DATA_WIDTH*INPUT_SIZE-1:0] din,
  input  logic [OUTPUT_SIZE-1:0]           req_r,
  output logic [OUTPUT_SIZE-1:0]           ack_r,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic [31:0]                      fire_count,
  output logic                             overflow
);

  localparam int CW = clog2(DEPTH) + 1;
  localparam bit IMM_OP = (OP == OP_ADDI) || (OP == OP_SUBI) || (OP == OP_MULI);

  if (INPUT_SIZE < 1 || INPUT_SIZE > 3) begin : g_bad_input_size
    $error("elastic_operator: INPUT_SIZE must be 1..3");
  end
  if (OUTPUT_SIZE < 1 || OUTPUT_SIZE > 4) begin : g_bad_output_size
    $error("elastic_operator: OUTPUT_SIZE must be 1..4");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("elastic_operator: DEPTH must be a power of two, at least 2");
  end
  if (IMM_OP && INPUT_SIZE > 1) begin : g_bad_imm_op
    $error("elastic_operator: immediate operations take a single lane");
  end

  logic [DATA_WIDTH-1:0]  head  [INPUT_SIZE];
  logic [CW-1:0]          count [INPUT_SIZE];
  logic [INPUT_SIZE-1:0]  full;
  logic [INPUT_SIZE-1:0]  empty;
  logic [INPUT_SIZE-1:0]  push;
  logic [INPUT_SIZE-1:0]  req_l_next;
  logic [OUTPUT_SIZE-1:0] pending;
  logic [OUTPUT_SIZE-1:0] pending_next;
  logic [OUTPUT_SIZE-1:0] grant;
  logic [DATA_WIDTH-1:0]  result;
  logic                   fire;

  for (genvar i = 0; i < INPUT_SIZE; i++) begin : g_lane
    // Data is accepted whenever there is room, even without an outstanding request.
    assign push[i] = ack_l[i] && !full[i];

    elastic_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_fifo (
      .clk  (clk),
      .rst  (rst),
      .push (push[i]),
      .pop  (fire),
      .din  (din[DATA_WIDTH*i +: DATA_WIDTH]),
      .dout (head[i]),
      .count(count[i]),
      .full (full[i]),
      .empty(empty[i])
    );

    assign req_l_next[i] = !ack_l[i] &&
                           ((count[i] + CW'(push[i]) - CW'(fire)) < CW'(DEPTH));
  end

  // A consumer stays pending through its ack_r cycle, so dout cannot change
  // while any consumer is still looking at its data-valid pulse.
  assign grant        = pending & req_r & ~ack_r;
  assign pending_next = pending & ~ack_r;
  assign fire         = (empty == '0) && (pending_next == '0);

  // NOTE: result gets a value before the case, so every path assigns it and
  // no latch is inferred for the operations that leave it untouched.
  always_comb begin
    result = head[0];
    case (OP)
      OP_ADDI: result = head[0] + IMMEDIATE;
      OP_SUBI: result = head[0] - IMMEDIATE;
      OP_MULI: result = head[0] * IMMEDIATE;
      OP_ADD:  for (int i = 1; i < INPUT_SIZE; i++) result = result + head[i];
      OP_SUB:  for (int i = 1; i < INPUT_SIZE; i++) result = result - head[i];
      OP_MUL:  for (int i = 1; i < INPUT_SIZE; i++) result = result * head[i];
      default: result = head[0];
    endcase
  end

  // NOTE: state updates use non-blocking assignment so every register samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      req_l      <= '0;
      ack_r      <= '0;
      pending    <= '0;
      dout       <= '0;
      fire_count <= '0;
      overflow   <= 1'b0;
    end else begin
      req_l   <= req_l_next;
      ack_r   <= grant;
      pending <= fire ? '1 : pending_next;
      if (fire) begin
        dout       <= result;
        fire_count <= fire_count + 32'd1;
      end
      if ((ack_l & full) != '0) overflow <= 1'b1;
    end
  end

endmodule
